// File: rtl/mp_ooo_dp_sram_ctrl_if.sv
// mp_ooo_dp_sram_ctrl_if
//
// Bus bundle for the mp_ooo dual-port SRAM model. Both ports share one clock
// that lives outside the interface.
//
// Signals:
//   ready            SRAM -> user  clear sweep finished, requests accepted
//   collision        SRAM -> user  pulse: both ports wrote one address
//   csbN             user -> SRAM  port N active-low chip select
//   webN             user -> SRAM  port N active-low write enable
//   wmaskN[lanes]    user -> SRAM  port N lane write mask, 1 = write lane
//   addrN            user -> SRAM  port N address
//   dinN             user -> SRAM  port N write data
//   doutN            SRAM -> user  port N registered read data
//
// Modports: master (requester side), slave (the SRAM).

interface mp_ooo_dp_sram_ctrl_if #(
   parameter int unsigned DATA_WIDTH = 3,
   parameter int unsigned ADDR_WIDTH = 9,
   parameter int unsigned LANE_WIDTH = 1
);
   localparam int unsigned NUM_LANES = DATA_WIDTH / LANE_WIDTH;

   logic                  ready;
   logic                  collision;

   logic                  csb0;
   logic                  web0;
   logic [NUM_LANES-1:0]  wmask0;
   logic [ADDR_WIDTH-1:0] addr0;
   logic [DATA_WIDTH-1:0] din0;
   logic [DATA_WIDTH-1:0] dout0;

   logic                  csb1;
   logic                  web1;
   logic [NUM_LANES-1:0]  wmask1;
   logic [ADDR_WIDTH-1:0] addr1;
   logic [DATA_WIDTH-1:0] din1;
   logic [DATA_WIDTH-1:0] dout1;

   modport master (
      input  ready, collision, dout0, dout1,
      output csb0, web0, wmask0, addr0, din0,
      output csb1, web1, wmask1, addr1, din1
   );

   modport slave (
      output ready, collision, dout0, dout1,
      input  csb0, web0, wmask0, addr0, din0,
      input  csb1, web1, wmask1, addr1, din1
   );
endinterface

// File: rtl/mp_ooo_dp_sram_ctrl.sv
// mp_ooo_dp_sram_ctrl
//
// Parametrised dual-port SRAM behavioural model. Both ports read/write on one
// clock, with per-lane write masks. After reset a hardware sweep writes zero
// to every word (RAM_DEPTH cycles); ready rises when the sweep completes and
// requests are ignored until then.
//
// Ports:
//   clk   clock
//   rst   asynchronous active-high reset, restarts the clear sweep
//   bus   mp_ooo_dp_sram_ctrl_if.slave: ready, collision, and per-port
//         csbN/webN/wmaskN/addrN/dinN/doutN
//
// Collision: on a same-address write from both ports, port 0 owns every lane
// it writes; port 1 only lands lanes port 0 left alone.
//
// Optional feature macro: SRAM_WRITE_FORWARD_EN
//   defined     a read hitting the address the other port writes on the same
//               edge returns the merged post-write word
//   undefined   such a read returns the pre-write word (read-first)

module mp_ooo_dp_sram_ctrl #(
   parameter int unsigned DATA_WIDTH = 3,
   parameter int unsigned ADDR_WIDTH = 9,
   parameter int unsigned LANE_WIDTH = 1
) (
   input logic                  clk,
   input logic                  rst,
   mp_ooo_dp_sram_ctrl_if.slave bus
);
   localparam int unsigned NUM_LANES = DATA_WIDTH / LANE_WIDTH;
   localparam int unsigned RAM_DEPTH = 1 << ADDR_WIDTH;

   if (DATA_WIDTH % LANE_WIDTH != 0) begin : g_lane_check
      $error("DATA_WIDTH must be a multiple of LANE_WIDTH");
   end

   typedef enum logic [0:0] {StInit, StReady} state_e;

   state_e                state;
   logic [ADDR_WIDTH-1:0] clr_cnt;
   logic                  ready_q;
   logic                  collision_q;
   logic [DATA_WIDTH-1:0] dout0_q;
   logic [DATA_WIDTH-1:0] dout1_q;

   logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

   logic                  rd0, wr0, rd1, wr1;
   logic [DATA_WIDTH-1:0] rd_word0, rd_word1;

   assign rd0 = (state == StReady) && !bus.csb0 && bus.web0;
   assign wr0 = (state == StReady) && !bus.csb0 && !bus.web0;
   assign rd1 = (state == StReady) && !bus.csb1 && bus.web1;
   assign wr1 = (state == StReady) && !bus.csb1 && !bus.web1;

   always_comb begin
      rd_word0 = mem[bus.addr0];
      rd_word1 = mem[bus.addr1];
`ifdef SRAM_WRITE_FORWARD_EN
      // Only the other port can write while this port reads, so the merge
      // never involves a collision.
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         if (wr1 && (bus.addr1 == bus.addr0) && bus.wmask1[i]) begin
            rd_word0[i*LANE_WIDTH +: LANE_WIDTH] = bus.din1[i*LANE_WIDTH +: LANE_WIDTH];
         end
         if (wr0 && (bus.addr0 == bus.addr1) && bus.wmask0[i]) begin
            rd_word1[i*LANE_WIDTH +: LANE_WIDTH] = bus.din0[i*LANE_WIDTH +: LANE_WIDTH];
         end
      end
`endif
   end

   // Control FSM with registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= StInit;
         clr_cnt     <= '0;
         ready_q     <= 1'b0;
         collision_q <= 1'b0;
         dout0_q     <= '0;
         dout1_q     <= '0;
      end else begin
         unique case (state)
            StInit: begin
               clr_cnt     <= clr_cnt + ADDR_WIDTH'(1);
               collision_q <= 1'b0;
               if (&clr_cnt) begin
                  state   <= StReady;
                  ready_q <= 1'b1;
               end
            end
            StReady: begin
               if (rd0) dout0_q <= rd_word0;
               if (rd1) dout1_q <= rd_word1;
               collision_q <= wr0 && wr1 && (bus.addr0 == bus.addr1);
            end
            default: state <= StInit;
         endcase
      end
   end

   // Array storage, deliberately not reset; the sweep clears it. Port 0 is
   // written last so it wins any lane both ports write.
   always_ff @(posedge clk) begin
      if (state == StInit) begin
         mem[clr_cnt] <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (wr1 && bus.wmask1[i]) begin
               mem[bus.addr1][i*LANE_WIDTH +: LANE_WIDTH] <= bus.din1[i*LANE_WIDTH +: LANE_WIDTH];
            end
            if (wr0 && bus.wmask0[i]) begin
               mem[bus.addr0][i*LANE_WIDTH +: LANE_WIDTH] <= bus.din0[i*LANE_WIDTH +: LANE_WIDTH];
            end
         end
      end
   end

   assign bus.ready     = ready_q;
   assign bus.collision = collision_q;
   assign bus.dout0     = dout0_q;
   assign bus.dout1     = dout1_q;
endmodule

// File: tb/tb_mp_ooo_dp_sram_ctrl.sv
// Testbench for mp_ooo_dp_sram_ctrl (DATA_WIDTH=3, ADDR_WIDTH=9, LANE_WIDTH=1).
// Inputs change 1 time unit after the rising edge; outputs are checked there.

module tb_mp_ooo_dp_sram_ctrl;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   mp_ooo_dp_sram_ctrl_if #(.DATA_WIDTH(3), .ADDR_WIDTH(9), .LANE_WIDTH(1)) bus ();

   mp_ooo_dp_sram_ctrl #(.DATA_WIDTH(3), .ADDR_WIDTH(9), .LANE_WIDTH(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

`ifdef SRAM_WRITE_FORWARD_EN
   localparam logic [2:0] Fwd20 = 3'b111;
   localparam logic [2:0] Fwd21 = 3'b100;
`else
   localparam logic [2:0] Fwd20 = 3'b000;
   localparam logic [2:0] Fwd21 = 3'b000;
`endif

   typedef struct {
      logic       csb0;
      logic       web0;
      logic [2:0] wm0;
      logic [8:0] a0;
      logic [2:0] d0;
      logic       csb1;
      logic       web1;
      logic [2:0] wm1;
      logic [8:0] a1;
      logic [2:0] d1;
      logic [2:0] e0;
      logic [2:0] e1;
      logic       ec;
   } vec_t;

   vec_t vecs [17];
   int   pass_cnt = 0;
   int   total_cnt = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      else pass_cnt++;
   endtask

   task automatic idle();
      bus.csb0 = 1'b1; bus.web0 = 1'b1; bus.wmask0 = '0; bus.addr0 = '0; bus.din0 = '0;
      bus.csb1 = 1'b1; bus.web1 = 1'b1; bus.wmask1 = '0; bus.addr1 = '0; bus.din1 = '0;
   endtask

   // Runs the clear sweep while hammering both ports with requests that must
   // be dropped; checks the sweep length and that outputs stay quiet.
   task automatic sweep(input string name);
      int  n = 0;
      bit  seen = 1'b0;
      bit  noisy = 1'b0;
      for (int c = 1; c <= 600 && !seen; c++) begin
         bus.csb0 = 1'b0; bus.csb1 = 1'b0;
         bus.addr0 = 9'h005; bus.addr1 = 9'h005;
         bus.din0 = 3'b111; bus.din1 = 3'b111;
         bus.wmask0 = 3'b111; bus.wmask1 = 3'b111;
         bus.web0 = c[0] ? 1'b0 : 1'b1;
         bus.web1 = c[0] ? 1'b0 : 1'b1;
         tick();
         if (bus.dout0 !== 3'b000 || bus.dout1 !== 3'b000 || bus.collision !== 1'b0) noisy = 1'b1;
         if (bus.ready === 1'b1) begin
            seen = 1'b1;
            n = c;
         end
      end
      idle();
      chk({name, "_cycles"}, n, 512);
      chk({name, "_quiet"}, {31'd0, noisy}, 0);
   endtask

   task automatic read_both(input logic [8:0] a0, input logic [8:0] a1);
      idle();
      bus.csb0 = 1'b0; bus.addr0 = a0;
      bus.csb1 = 1'b0; bus.addr1 = a1;
      tick();
      idle();
   endtask

   initial begin
      int bad;
      // csb0 web0 wm0 a0 d0 | csb1 web1 wm1 a1 d1 | exp dout0 dout1 collision
      vecs[0]  = '{0,0,3'b111,9'h005,3'b101, 1,1,3'b000,9'h000,3'b000, 3'b000,3'b000,0};
      vecs[1]  = '{1,1,3'b000,9'h000,3'b000, 0,1,3'b000,9'h005,3'b000, 3'b000,3'b101,0};
      vecs[2]  = '{0,1,3'b000,9'h005,3'b000, 1,1,3'b000,9'h000,3'b000, 3'b101,3'b101,0};
      vecs[3]  = '{1,1,3'b000,9'h000,3'b000, 0,0,3'b010,9'h010,3'b111, 3'b101,3'b101,0};
      vecs[4]  = '{0,1,3'b000,9'h010,3'b000, 0,1,3'b000,9'h010,3'b000, 3'b010,3'b010,0};
      vecs[5]  = '{0,0,3'b011,9'h1FF,3'b001, 0,0,3'b110,9'h1FF,3'b110, 3'b010,3'b010,1};
      vecs[6]  = '{0,1,3'b000,9'h1FF,3'b000, 0,1,3'b000,9'h1FF,3'b000, 3'b101,3'b101,0};
      vecs[7]  = '{0,0,3'b000,9'h030,3'b111, 0,0,3'b000,9'h030,3'b111, 3'b101,3'b101,1};
      vecs[8]  = '{0,1,3'b000,9'h030,3'b000, 0,1,3'b000,9'h030,3'b000, 3'b000,3'b000,0};
      vecs[9]  = '{0,0,3'b111,9'h040,3'b011, 0,0,3'b111,9'h041,3'b100, 3'b000,3'b000,0};
      vecs[10] = '{0,1,3'b000,9'h041,3'b000, 0,1,3'b000,9'h040,3'b000, 3'b100,3'b011,0};
      vecs[11] = '{0,0,3'b111,9'h020,3'b111, 0,1,3'b000,9'h020,3'b000, 3'b100,Fwd20,0};
      vecs[12] = '{1,1,3'b000,9'h000,3'b000, 0,1,3'b000,9'h020,3'b000, 3'b100,3'b111,0};
      vecs[13] = '{0,1,3'b000,9'h021,3'b000, 0,0,3'b100,9'h021,3'b110, Fwd21,3'b111,0};
      vecs[14] = '{0,1,3'b000,9'h021,3'b000, 1,1,3'b000,9'h000,3'b000, 3'b100,3'b111,0};
      vecs[15] = '{1,0,3'b111,9'h005,3'b000, 1,0,3'b111,9'h005,3'b000, 3'b100,3'b111,0};
      vecs[16] = '{0,1,3'b000,9'h005,3'b000, 0,1,3'b000,9'h1FF,3'b000, 3'b101,3'b101,0};

      // Reset state.
      idle();
      rst = 1'b1;
      repeat (3) tick();
      chk("reset_ready", {31'd0, bus.ready}, 0);
      chk("reset_collision", {31'd0, bus.collision}, 0);
      chk("reset_dout0", {29'd0, bus.dout0}, 0);
      chk("reset_dout1", {29'd0, bus.dout1}, 0);
      rst = 1'b0;
      sweep("sweep1");

      // Every word reads back zero after the sweep.
      bad = 0;
      for (int a = 0; a < 512; a++) begin
         read_both(9'(a), 9'(511 - a));
         if (bus.dout0 !== 3'b000 || bus.dout1 !== 3'b000) bad++;
      end
      chk("sweep_zero", bad, 0);

      // Directed vectors.
      for (int i = 0; i < 17; i++) begin
         bus.csb0 = vecs[i].csb0; bus.web0 = vecs[i].web0; bus.wmask0 = vecs[i].wm0;
         bus.addr0 = vecs[i].a0; bus.din0 = vecs[i].d0;
         bus.csb1 = vecs[i].csb1; bus.web1 = vecs[i].web1; bus.wmask1 = vecs[i].wm1;
         bus.addr1 = vecs[i].a1; bus.din1 = vecs[i].d1;
         tick();
         chk($sformatf("vec%0d_dout0", i), {29'd0, bus.dout0}, {29'd0, vecs[i].e0});
         chk($sformatf("vec%0d_dout1", i), {29'd0, bus.dout1}, {29'd0, vecs[i].e1});
         chk($sformatf("vec%0d_collision", i), {31'd0, bus.collision}, {31'd0, vecs[i].ec});
      end
      idle();

      // Reset in READY: write 9'h05, then assert rst between edges.
      bus.csb0 = 1'b0; bus.web0 = 1'b0; bus.wmask0 = 3'b111; bus.addr0 = 9'h005;
      bus.din0 = 3'b111;
      tick();
      idle();
      chk("ready_before_rst", {31'd0, bus.ready}, 1);
      #2 rst = 1'b1;
      #1;
      chk("rst_ready_async", {31'd0, bus.ready}, 0);
      chk("rst_dout0_async", {29'd0, bus.dout0}, 0);
      chk("rst_dout1_async", {29'd0, bus.dout1}, 0);
      tick();
      rst = 1'b0;

      // Reset again 100 cycles into the sweep; the sweep must restart.
      repeat (100) tick();
      chk("midsweep_ready", {31'd0, bus.ready}, 0);
      #2 rst = 1'b1;
      tick();
      rst = 1'b0;
      sweep("sweep2");

      read_both(9'h005, 9'h1FF);
      chk("recleared_05_p0", {29'd0, bus.dout0}, 0);
      chk("recleared_1ff_p1", {29'd0, bus.dout1}, 0);
      read_both(9'h000, 9'h005);
      chk("recleared_000_p0", {29'd0, bus.dout0}, 0);
      chk("recleared_05_p1", {29'd0, bus.dout1}, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation timed out, %0d/%0d passed", pass_cnt, total_cnt);
      $fatal(1);
   end
endmodule
